// File: rtl/mem_port_arbiter_if.sv
// Master-side bus bundle for mem_port_arbiter: request payload in, grant/rvalid strobes back.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single synchronous memory port using 2-cycle ADDR/DATA slots.
// Optional MEM_ARB_FIXED_PRI_EN: fixed priority (M0 wins ties) instead of round-robin.
module mem_port_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_port_arbiter_if.slave    m0_if,
    mem_port_arbiter_if.slave    m1_if,
    output logic [DW-1:0]        rdata_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_dout_o,
    output logic                 mem_w_o,
    input  logic [DW-1:0]        mem_din_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;     // 0 = M0, 1 = M1 owns the slot in flight
    logic          rd_q, rd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_dout_q, mem_dout_d;
    logic          mem_w_q, mem_w_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          m0_gnt_q, m0_gnt_d;
    logic          m1_gnt_q, m1_gnt_d;
    logic          m0_rvalid_q, m0_rvalid_d;
    logic          m1_rvalid_q, m1_rvalid_d;
    logic          any_req;
    logic          win1;

`ifndef MEM_ARB_FIXED_PRI_EN
    logic          last_q, last_d;       // 1 = M1 was the last master granted
`endif

    assign any_req = m0_if.req | m1_if.req;

`ifdef MEM_ARB_FIXED_PRI_EN
    assign win1 = m1_if.req & ~m0_if.req;
`else
    assign win1 = m1_if.req & (~m0_if.req | ~last_q);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rd_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            mem_w_q     <= 1'b0;
            rdata_q     <= '0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRI_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            mem_w_q     <= mem_w_d;
            rdata_q     <= rdata_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
`ifndef MEM_ARB_FIXED_PRI_EN
            last_q      <= last_d;
`endif
        end
    end

    // Next-state: gnt/mem_w/mem_addr are loaded on the edge entering ADDR so they appear in ADDR.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        mem_w_d     = 1'b0;
        rdata_d     = rdata_q;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
`ifndef MEM_ARB_FIXED_PRI_EN
        last_d      = last_q;
`endif

        case (state_q)
            IDLE, DATA: begin
                // Read data from the slot just finished is captured on the same edge a new slot launches
                if (state_q == DATA && rd_q) begin
                    rdata_d     = mem_din_i;
                    m0_rvalid_d = ~owner_q;
                    m1_rvalid_d = owner_q;
                end
                if (any_req) begin
                    state_d    = ADDR;
                    owner_d    = win1;
                    rd_d       = win1 ? ~m1_if.we : ~m0_if.we;
                    mem_addr_d = win1 ? m1_if.addr : m0_if.addr;
                    mem_dout_d = win1 ? m1_if.wdata : m0_if.wdata;
                    mem_w_d    = win1 ? m1_if.we : m0_if.we;
                    m0_gnt_d   = ~win1;
                    m1_gnt_d   = win1;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                state_d = DATA;
`ifndef MEM_ARB_FIXED_PRI_EN
                last_d  = owner_q;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m0_if.gnt    = m0_gnt_q;
    assign m1_if.gnt    = m1_gnt_q;
    assign m0_if.rvalid = m0_rvalid_q;
    assign m1_if.rvalid = m1_rvalid_q;
    assign rdata_o      = rdata_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_dout_o   = mem_dout_q;
    assign mem_w_o      = mem_w_q;

endmodule
